// File: rtl/lane_striper_pkg.sv
// Shared symbols, FSM encoding and sizing helper for the lane striper transmitter.
package lane_striper_pkg;

  localparam logic [7:0] PAD_SYM = 8'hF7;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_striper_skp_sched.sv
// Counts emitted data groups and raises a skip request once SKP_INTERVAL groups have gone out.
module lane_striper_skp_sched #(
  parameter int SKP_INTERVAL = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic grp_emit_i,
  input  logic skp_emit_i,
  output logic skp_req_o
);

  localparam int CW = $clog2(SKP_INTERVAL + 1);

  logic [CW-1:0] cnt_q;

  // Data moves are blocked while the request is up, so the count never passes the interval.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (skp_emit_i) begin
      cnt_q <= '0;
    end else if (grp_emit_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign skp_req_o = (cnt_q >= CW'(SKP_INTERVAL));

endmodule

// File: rtl/lane_striper_tx.sv
// Byte-to-lane striping transmitter with timeout padding of partial groups.
// Optional periodic skip-group insertion is enabled by defining LANE_STRIPER_SKP_EN.
module lane_striper_tx
  import lane_striper_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int WIDTH         = 8,
  parameter int FLUSH_TIMEOUT = 8,
  parameter int SKP_INTERVAL  = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_pad_mask,
  output logic                   out_skp,
  output state_t                 dbg_state
);

  // Handshake: a symbol moves on in_valid && in_ready, a word on out_valid && out_ready.
  // in_ready comes from a register; out_ready never reaches it combinationally.

  localparam int IW = lane_idx_w(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic [7:0] TO_M1 = 8'(FLUSH_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] PAD_W = WIDTH'(PAD_SYM);
  localparam logic [WIDTH-1:0] SKP_W = WIDTH'(SKP_SYM);

  typedef logic [LANES-1:0][WIDTH-1:0] word_t;

  localparam word_t SKP_WORD = {LANES{SKP_W}};

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      idle_q;
  word_t           buf_q;
  word_t           out_data_q;
  logic            out_valid_q;
  logic [LANES-1:0] pad_mask_q;
  logic            skp_q;
  logic            in_ready_q;

  logic            slot_free;
  logic            accept;
  logic            fill_done;
  logic            flush_due;
  logic            skp_req;
  logic            data_slot;
  logic            take_skp;
  logic            grp_emit;
  word_t           full_word;
  word_t           flush_word;
  logic [LANES-1:0] flush_mask;

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready_q;
  assign fill_done = accept && (idx_q == LAST);
  assign flush_due = (state_q == ST_FILL) && !accept && (idx_q != '0) && (idle_q >= TO_M1);
  // A pending skip group takes the free slot ahead of any data move.
  assign data_slot = slot_free && !skp_req;
  assign take_skp  = slot_free && skp_req;
  assign grp_emit  = data_slot && (fill_done || flush_due || (state_q == ST_FULL));

  always_comb begin
    full_word = buf_q;
    full_word[LANES-1] = in_data;
    flush_word = buf_q;
    flush_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k >= int'(idx_q)) begin
        flush_word[k] = PAD_W;
        flush_mask[k] = 1'b1;
      end
    end
  end

`ifdef LANE_STRIPER_SKP_EN
  lane_striper_skp_sched #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_sched (
    .CLK        (CLK),
    .RESET      (RESET),
    .grp_emit_i (grp_emit),
    .skp_emit_i (take_skp),
    .skp_req_o  (skp_req)
  );
`else
  logic unused_skp_interval;
  assign unused_skp_interval = |SKP_INTERVAL;
  assign skp_req = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      idle_q      <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pad_mask_q  <= '0;
      skp_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (take_skp) begin
        out_data_q  <= SKP_WORD;
        pad_mask_q  <= '0;
        skp_q       <= 1'b1;
        out_valid_q <= 1'b1;
      end
      case (state_q)
        ST_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buf_q[idx_q] <= in_data;
            idle_q       <= '0;
            if (idx_q == LAST) begin
              if (data_slot) begin
                out_data_q  <= full_word;
                pad_mask_q  <= '0;
                skp_q       <= 1'b0;
                out_valid_q <= 1'b1;
                idx_q       <= '0;
              end else begin
                state_q    <= ST_FULL;
                in_ready_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (idx_q == '0) begin
            idle_q <= '0;
          end else if (idle_q >= TO_M1) begin
            // Timed out: pad the partial group as soon as the output slot frees up.
            if (data_slot) begin
              out_data_q  <= flush_word;
              pad_mask_q  <= flush_mask;
              skp_q       <= 1'b0;
              out_valid_q <= 1'b1;
              idx_q       <= '0;
              idle_q      <= '0;
            end
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_FULL: begin
          if (data_slot) begin
            out_data_q  <= buf_q;
            pad_mask_q  <= '0;
            skp_q       <= 1'b0;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_FILL;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_pad_mask = pad_mask_q;
  assign out_skp      = skp_q;
  assign dbg_state    = state_q;

endmodule
